// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the key debouncer and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debounce_pkg;

  // Default build values for the board push-button front end.
  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_HOLD_TICKS   = 500;
  localparam int DEF_REPEAT_TICKS = 100;

  // Bits needed to hold any value in 0..max_val (never less than 1).
  function automatic int ctr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Per-key event bundle handed to the control FSM.
  typedef struct packed {
    logic state;       // debounced level, 1 = pressed
    logic down;        // press accepted this cycle
    logic up;          // release accepted this cycle
    logic long_press;  // hold threshold reached this cycle
    logic auto_rep;    // auto-repeat strobe this cycle
  } key_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-FF sync, stability-count debounce, hold-time and auto-repeat strobes.
// Latency: a clean level change appears 2**CNT_WIDTH+2 clocks after first sampling.
// Backpressure: none; strobes are single-cycle and must be consumed when they appear.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     level,      // raw pin, already normalised to 1 = pressed
  input  logic     tick,       // shared hold-time prescaler pulse
  output logic     state_nxt,  // debounced level as it will be after this edge
  output key_evt_t evt
);

  localparam int HW = ctr_width(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  logic [1:0]           sync;
  logic [CNT_WIDTH-1:0] cnt;
  logic [HW-1:0]        hold_cnt;
  logic                 st_q, dn_q, up_q, lg_q, rp_q;
  logic                 mismatch, toggle, hold_step, hold_sat, long_hit;

  assign mismatch  = sync[1] != st_q;
  assign toggle    = mismatch && (&cnt);
  assign state_nxt = st_q ^ toggle;
  // Ticks landing on a press/release edge do not count toward the hold time.
  assign hold_step = st_q && !toggle && tick;
  assign hold_sat  = hold_cnt == HOLD_MAX;
  assign long_hit  = hold_step && (hold_cnt == HOLD_LAST);

  // Two-flop synchroniser; clears to the released level.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], level};
  end

  // Debounce: count consecutive mismatching clocks, flip the level on the all-ones count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      st_q <= 1'b0;
      dn_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      cnt  <= (mismatch && !toggle) ? cnt + CNT_WIDTH'(1) : '0;
      st_q <= state_nxt;
      dn_q <= toggle && !st_q;
      up_q <= toggle && st_q;
    end
  end

  // Hold timer: counts ticks while pressed, saturates, fires the long strobe once.
  always_ff @(posedge clk) begin
    if (reset || toggle || !st_q) begin
      hold_cnt <= '0;
      lg_q     <= 1'b0;
    end else begin
      lg_q <= long_hit;
      if (hold_step && !hold_sat) hold_cnt <= hold_cnt + HW'(1);
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int RW = ctr_width(REPEAT_TICKS);
      localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
      logic [RW-1:0] rep_cnt;
      logic          rp_r;

      // Repeat timer: restarts at the long strobe, pulses every REPEAT_TICKS ticks after it.
      always_ff @(posedge clk) begin
        if (reset || toggle || !st_q || long_hit) begin
          rep_cnt <= '0;
          rp_r    <= 1'b0;
        end else begin
          rp_r <= 1'b0;
          if (hold_step && hold_sat) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt <= '0;
              rp_r    <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
        end
      end

      assign rp_q = rp_r;
    end else begin : g_norep
      assign rp_q = 1'b0;
    end
  endgenerate

  assign evt = '{state: st_q, down: dn_q, up: up_q, long_press: lg_q, auto_rep: rp_q};

endmodule

// File: rtl/multi_key_debouncer.sv
// N-key push-button front end: polarity fix-up, shared hold prescaler, per-key debounce channels.
// Latency: 2**CNT_WIDTH+2 clocks from a clean pin change to key_state_o; all outputs registered.
// Backpressure: none; strobes are single-cycle and must be consumed when they appear.
module multi_key_debouncer
  import debounce_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_state_o,
  output logic [N_KEYS-1:0] key_down_o,
  output logic [N_KEYS-1:0] key_up_o,
  output logic [N_KEYS-1:0] key_long_o,
  output logic [N_KEYS-1:0] key_repeat_o,
  output logic              key_any_o
);

  localparam int PW = ctr_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc;
  logic              tick;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] state_nxt;

  // Internal level is always 1 = pressed, whatever the board wiring.
  assign level = ACTIVE_LOW ? ~key_i : key_i;
  assign tick  = presc == PRESC_LAST;

  // Free-running hold prescaler shared by all keys; not aligned to any press.
  always_ff @(posedge clk) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + PW'(1);
  end

  generate
    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_evt_t evt;

      debounce_channel #(
        .CNT_WIDTH   (CNT_WIDTH),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_EN   (REPEAT_EN),
        .REPEAT_TICKS(REPEAT_TICKS)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .level    (level[g]),
        .tick     (tick),
        .state_nxt(state_nxt[g]),
        .evt      (evt)
      );

      assign key_state_o[g]  = evt.state;
      assign key_down_o[g]   = evt.down;
      assign key_up_o[g]     = evt.up;
      assign key_long_o[g]   = evt.long_press;
      assign key_repeat_o[g] = evt.auto_rep;
    end
  endgenerate

  // Any-key flag taken from next state so it lines up with key_state_o.
  always_ff @(posedge clk) begin
    if (reset) key_any_o <= 1'b0;
    else       key_any_o <= |state_nxt;
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Self-checking bench: two DUTs (active-low and active-high pins) against one reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_key_debouncer;

  localparam int NK = 4;
  localparam int CW = 3;
  localparam int TD = 4;
  localparam int HT = 3;
  localparam int RT = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] pins  = 4'hF;  // pin levels for the active-low DUT
  logic [NK-1:0] pins_b;

  logic [NK-1:0] a_state, a_down, a_up, a_long, a_rep;
  logic [NK-1:0] b_state, b_down, b_up, b_long, b_rep;
  logic          a_any, b_any;
  logic [20:0]   a_vec, b_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model state, expressed in terms of run lengths and tick counts.
  logic [NK-1:0] m_st, m_s0, m_s1, m_dn, m_up, m_lg, m_rp;
  logic          m_any;
  int            m_run  [NK];
  int            m_held [NK];
  int            m_cyc;
  logic          model_ok = 1'b0;

  typedef struct {
    logic [NK-1:0] pins;
    int            ncyc;
    logic [NK-1:0] st;
    logic [NK-1:0] dn_m, up_m, lg_m, rp_m;
    int            dn_n, up_n, lg_n, rp_n;
  } vec_t;

  vec_t tbl [14];

  assign pins_b = ~pins;
  assign a_vec  = {a_state, a_down, a_up, a_long, a_rep, a_any};
  assign b_vec  = {b_state, b_down, b_up, b_long, b_rep, b_any};

  always #5 clk = ~clk;

  multi_key_debouncer #(
    .N_KEYS(NK), .CNT_WIDTH(CW), .ACTIVE_LOW(1'b1), .TICK_DIV(TD),
    .HOLD_TICKS(HT), .REPEAT_EN(1'b1), .REPEAT_TICKS(RT)
  ) dut_a (
    .clk(clk), .reset(reset), .key_i(pins),
    .key_state_o(a_state), .key_down_o(a_down), .key_up_o(a_up),
    .key_long_o(a_long), .key_repeat_o(a_rep), .key_any_o(a_any)
  );

  multi_key_debouncer #(
    .N_KEYS(NK), .CNT_WIDTH(CW), .ACTIVE_LOW(1'b0), .TICK_DIV(TD),
    .HOLD_TICKS(HT), .REPEAT_EN(1'b1), .REPEAT_TICKS(RT)
  ) dut_b (
    .clk(clk), .reset(reset), .key_i(pins_b),
    .key_state_o(b_state), .key_down_o(b_down), .key_up_o(b_up),
    .key_long_o(b_long), .key_repeat_o(b_rep), .key_any_o(b_any)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [NK-1:0] press;
    logic tick, mism, tog;
    press = ~pins;
    if (reset) begin
      m_st = '0; m_s0 = '0; m_s1 = '0;
      m_dn = '0; m_up = '0; m_lg = '0; m_rp = '0;
      m_any = 1'b0;
      m_cyc = 0;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  = 0;
        m_held[k] = 0;
      end
      model_ok = 1'b1;
    end else begin
      tick  = (m_cyc % TD) == TD - 1;
      m_cyc = m_cyc + 1;
      for (int k = 0; k < NK; k++) begin
        mism     = m_s1[k] != m_st[k];
        m_run[k] = mism ? m_run[k] + 1 : 0;
        tog      = m_run[k] == (1 << CW);
        if (tog) m_run[k] = 0;
        m_dn[k] = tog && !m_st[k];
        m_up[k] = tog && m_st[k];
        m_lg[k] = 1'b0;
        m_rp[k] = 1'b0;
        if (tog || !m_st[k]) begin
          m_held[k] = 0;
        end else if (tick) begin
          m_held[k] = m_held[k] + 1;
          m_lg[k]   = m_held[k] == HT;
          m_rp[k]   = (m_held[k] > HT) && (((m_held[k] - HT) % RT) == 0);
        end
        if (tog) m_st[k] = ~m_st[k];
        m_s1[k] = m_s0[k];
        m_s0[k] = press[k];
      end
      m_any = |m_st;
    end
  endtask

  // One clock: model on the rising edge, compare both DUTs on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (model_ok) begin
      chk("model_a", 32'(a_vec), 32'({m_st, m_dn, m_up, m_lg, m_rp, m_any}));
      chk("model_b", 32'(b_vec), 32'({m_st, m_dn, m_up, m_lg, m_rp, m_any}));
    end
  endtask

  initial begin
    logic [NK-1:0] dn_m, up_m, lg_m, rp_m;
    int dn_n, up_n, lg_n, rp_n;

    // {pins, cycles, state, down/up/long/rep masks, down/up/long/rep strobe-cycle counts}
    tbl[0]  = '{4'hF, 12, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
    tbl[1]  = '{4'hE, 30, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 1, 0, 1, 1};
    tbl[2]  = '{4'hF, 10, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 0, 1, 0, 1};
    tbl[3]  = '{4'hF, 12, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      tbl[4 + 2 * i] = '{4'hD, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
      tbl[5 + 2 * i] = '{4'hF, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
    end
    tbl[10] = '{4'hB, 9,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
    tbl[11] = '{4'hF, 12, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 1, 1, 0, 0};
    tbl[12] = '{4'h5, 8,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0};
    tbl[13] = '{4'hF, 14, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0, 1, 1, 0, 0};

    // Reset state.
    reset = 1'b1;
    pins  = 4'hF;
    step();
    step();
    chk("reset_a", 32'(a_vec), 32'h0);
    chk("reset_b", 32'(b_vec), 32'h0);
    reset = 1'b0;
    repeat (4) step();

    // Exact press latency on key 0.
    pins = 4'hE;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 9) begin
        chk("lat_pre_a", 32'(a_state), 32'h0);
        chk("lat_pre_b", 32'(b_state), 32'h0);
      end
      if (e == 10) begin
        chk("lat_edge_a", 32'(a_vec), 32'({4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}));
        chk("lat_edge_b", 32'(b_vec), 32'({4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1}));
      end
      if (e == 11) begin
        chk("lat_post_a", 32'({a_state, a_down}), 32'({4'h1, 4'h0}));
        chk("lat_post_b", 32'({b_state, b_down}), 32'({4'h1, 4'h0}));
      end
    end
    pins = 4'hF;
    repeat (14) step();

    // Table-driven scenarios from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < 14; r++) begin
      pins = tbl[r].pins;
      dn_m = '0; up_m = '0; lg_m = '0; rp_m = '0;
      dn_n = 0;  up_n = 0;  lg_n = 0;  rp_n = 0;
      for (int c = 0; c < tbl[r].ncyc; c++) begin
        step();
        if (|a_down) begin dn_m |= a_down; dn_n++; end
        if (|a_up)   begin up_m |= a_up;   up_n++; end
        if (|a_long) begin lg_m |= a_long; lg_n++; end
        if (|a_rep)  begin rp_m |= a_rep;  rp_n++; end
      end
      chk($sformatf("rec%0d_state", r), 32'(a_state), 32'(tbl[r].st));
      chk($sformatf("rec%0d_masks", r), 32'({dn_m, up_m, lg_m, rp_m}),
          32'({tbl[r].dn_m, tbl[r].up_m, tbl[r].lg_m, tbl[r].rp_m}));
      chk($sformatf("rec%0d_counts", r), {8'(dn_n), 8'(up_n), 8'(lg_n), 8'(rp_n)},
          {8'(tbl[r].dn_n), 8'(tbl[r].up_n), 8'(tbl[r].lg_n), 8'(tbl[r].rp_n)});
    end

    // Reset in the middle of a debounce, key kept held.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    pins = 4'hE;
    repeat (7) step();
    reset = 1'b1;
    step();
    chk("rst_mid_a", 32'(a_vec), 32'h0);
    chk("rst_mid_b", 32'(b_vec), 32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9) begin
        chk("rst_pre_a", 32'(a_state), 32'h0);
        chk("rst_pre_b", 32'(b_state), 32'h0);
      end
      if (e == 10) begin
        chk("rst_down_a", 32'({a_state, a_down}), 32'({4'h1, 4'h1}));
        chk("rst_down_b", 32'({b_state, b_down}), 32'({4'h1, 4'h1}));
      end
    end
    pins = 4'hF;
    repeat (14) step();

    // Random key patterns and occasional resets against the model.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      pins = 4'($urandom);
      repeat ($urandom_range(1, 40)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
